// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port memory between instruction fetch and the
//   load/store unit. Only one transaction is in flight at a time. The data
//   side normally wins arbitration. Fetch is forced to win after it has lost
//   STARVE_MAX arbitrations in a row.
//
// Ports
//   clk, reset           clock (rising edge), asynchronous active-low reset
//   if_req/if_addr       fetch request in;  if_gnt, if_rvalid, if_rdata out
//   d_req/d_we/d_be/
//   d_addr/d_wdata       load/store request in; d_gnt, d_rvalid, d_rdata out
//   mem_req/we/be/
//   addr/wdata           memory strobe and command out
//   mem_rdata            memory read data in, valid MEM_LAT cycles after mem_req
//   busy                 a transaction is outstanding
//
// Optional build macro
//   ARB_PERF_EN          adds if_stall_cnt / d_stall_cnt. Each is a saturating
//                        count of cycles in which its request waited ungranted.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]           if_stall_cnt,
    output logic [31:0]           d_stall_cnt
`endif
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_q;
    logic        owner_q;     // 1 = data side owns the outstanding transaction
    logic [2:0]  lat_q;
    logic [3:0]  starve_q;

    logic resp;
    logic arb_ok;
    logic force_if;
    logic if_win;
    logic d_win;

    always_comb begin
        // The last wait cycle is also an arbitration cycle, so a new grant can
        // overlap the returning data. Reset gates arbitration so that every
        // output is 0 while reset is held.
        resp     = (state_q == WAIT) && (lat_q == 3'd1);
        arb_ok   = reset && ((state_q == IDLE) || resp);
        force_if = (starve_q == STARVE_LIM);
        if_win   = arb_ok && if_req && (!d_req || force_if);
        d_win    = arb_ok && d_req && !if_win;
    end

    assign if_gnt    = if_win;
    assign d_gnt     = d_win;
    assign mem_req   = if_win || d_win;
    assign mem_we    = d_win && d_we;
    assign mem_be    = d_win ? d_be : {(DATA_W/8){if_win}};
    assign mem_addr  = d_win ? d_addr : (if_win ? if_addr : '0);
    assign mem_wdata = d_win ? d_wdata : '0;

    assign if_rvalid = resp && !owner_q;
    assign d_rvalid  = resp && owner_q;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;

    // A response cycle counts as idle unless a new grant is issued in it.
    assign busy = (state_q == WAIT) && !(resp && !mem_req);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            lat_q    <= 3'd0;
            starve_q <= 4'd0;
        end else begin
            if (if_win || d_win) begin
                state_q <= WAIT;
                owner_q <= d_win;
                lat_q   <= LAT_INIT;
            end else if (resp || (state_q == IDLE)) begin
                state_q <= IDLE;
                lat_q   <= 3'd0;
            end else begin
                lat_q   <= lat_q - 3'd1;
            end

            // Count only lost arbitrations. Wait cycles with fetch pending hold the count.
            if (!if_req || if_win) begin
                starve_q <= 4'd0;
            end else if (arb_ok && (starve_q != STARVE_LIM)) begin
                starve_q <= starve_q + 4'd1;
            end
        end
    end

`ifdef ARB_PERF_EN
    logic [31:0] if_stall_q;
    logic [31:0] d_stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_stall_q <= 32'd0;
            d_stall_q  <= 32'd0;
        end else begin
            if (if_req && !if_win && (if_stall_q != 32'hFFFF_FFFF)) begin
                if_stall_q <= if_stall_q + 32'd1;
            end
            if (d_req && !d_win && (d_stall_q != 32'hFFFF_FFFF)) begin
                d_stall_q <= d_stall_q + 32'd1;
            end
        end
    end

    assign if_stall_cnt = if_stall_q;
    assign d_stall_cnt  = d_stall_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Three arbiters run side by side with MEM_LAT = 1, 2 and 3
//   (instance k has latency k+1). Each instance has its own delay-line memory.
//   Directed stimulus pushes the expected response onto a per-instance
//   scoreboard. A monitor pops each entry on its due cycle and compares it.
//   In every other cycle the monitor requires quiet rvalid/rdata.
module tb_mem_arbiter;

    localparam int NI = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          if_req    [NI];
    logic [AW-1:0] if_addr   [NI];
    logic          if_gnt    [NI];
    logic          if_rvalid [NI];
    logic [DW-1:0] if_rdata  [NI];
    logic          d_req     [NI];
    logic          d_we      [NI];
    logic [BW-1:0] d_be      [NI];
    logic [AW-1:0] d_addr    [NI];
    logic [DW-1:0] d_wdata   [NI];
    logic          d_gnt     [NI];
    logic          d_rvalid  [NI];
    logic [DW-1:0] d_rdata   [NI];
    logic          mem_req   [NI];
    logic          mem_we    [NI];
    logic [BW-1:0] mem_be    [NI];
    logic [AW-1:0] mem_addr  [NI];
    logic [DW-1:0] mem_wdata [NI];
    logic          busy      [NI];
`ifdef ARB_PERF_EN
    logic [31:0]   if_stall_cnt [NI];
    logic [31:0]   d_stall_cnt  [NI];
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents as a function of the address.
    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return (a ^ 32'h5A5A_0000) + 32'd7;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [DW-1:0] pipe [4];
        logic [DW-1:0] rdata_w;

        always @(posedge clk) begin
            pipe[0] <= mem_fn(mem_addr[g]);
            for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
        end
        assign rdata_w = pipe[g];

        mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(g + 1), .STARVE_MAX(4)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_gnt    (if_gnt[g]),
            .if_rvalid (if_rvalid[g]),
            .if_rdata  (if_rdata[g]),
            .d_req     (d_req[g]),
            .d_we      (d_we[g]),
            .d_be      (d_be[g]),
            .d_addr    (d_addr[g]),
            .d_wdata   (d_wdata[g]),
            .d_gnt     (d_gnt[g]),
            .d_rvalid  (d_rvalid[g]),
            .d_rdata   (d_rdata[g]),
            .mem_req   (mem_req[g]),
            .mem_we    (mem_we[g]),
            .mem_be    (mem_be[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (rdata_w),
            .busy      (busy[g])
`ifdef ARB_PERF_EN
            ,
            .if_stall_cnt (if_stall_cnt[g]),
            .d_stall_cnt  (d_stall_cnt[g])
`endif
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: one queue per instance.
    typedef struct {
        bit            is_d;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];

    function automatic int sb_size(input int k);
        case (k)
            0:       return sb0.size();
            1:       return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    function automatic int sb_due(input int k);
        case (k)
            0:       return sb0[0].due;
            1:       return sb1[0].due;
            default: return sb2[0].due;
        endcase
    endfunction

    function automatic exp_t sb_pop(input int k);
        case (k)
            0:       return sb0.pop_front();
            1:       return sb1.pop_front();
            default: return sb2.pop_front();
        endcase
    endfunction

    task automatic sb_push(input int k, input bit is_d, input logic [DW-1:0] d, input int due);
        exp_t e;
        e.is_d = is_d;
        e.data = d;
        e.due  = due;
        case (k)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    task automatic mon_one(input int k);
        exp_t e;
        if (sb_size(k) > 0 && sb_due(k) == cyc) begin
            e = sb_pop(k);
            chk($sformatf("rv_src%0d", k), {d_rvalid[k], if_rvalid[k]}, e.is_d ? 64'd2 : 64'd1);
            chk($sformatf("rdata%0d", k), e.is_d ? d_rdata[k] : if_rdata[k], e.data);
        end else begin
            chk($sformatf("rv_quiet%0d", k), {d_rvalid[k], if_rvalid[k]}, 64'd0);
        end
        if (!if_rvalid[k]) chk($sformatf("if_rdata_zero%0d", k), if_rdata[k], 64'd0);
        if (!d_rvalid[k])  chk($sformatf("d_rdata_zero%0d", k), d_rdata[k], 64'd0);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) mon_one(k);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Every output of instance k must be 0.
    task automatic chk_quiet(input int k, input string tag);
        chk({tag, "_ctl"}, {if_gnt[k], d_gnt[k], mem_req[k], mem_we[k], mem_be[k],
                            if_rvalid[k], d_rvalid[k], busy[k]}, 64'd0);
        chk({tag, "_dat"}, mem_addr[k] | mem_wdata[k] | if_rdata[k] | d_rdata[k], 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        for (int k = 0; k < NI; k++) begin
            if_req[k] = 1'b0; if_addr[k] = '0;
            d_req[k]  = 1'b0; d_we[k] = 1'b0; d_be[k] = '0;
            d_addr[k] = '0;   d_wdata[k] = '0;
        end

        // Reset held with a fetch pending on instance 0: nothing may be granted.
        repeat (2) @(posedge clk);
        #1;
        if_req[0] = 1'b1; if_addr[0] = 32'h10;
        sample();
        for (int k = 0; k < NI; k++) chk_quiet(k, $sformatf("rst%0d", k));
        step();
        reset = 1'b1; if_req[0] = 1'b0;
        sample();
        chk("idle_busy", busy[0], 1'b0);

        // Single fetch, MEM_LAT=1.
        step();
        if_req[0] = 1'b1; if_addr[0] = 32'h10;
        sample();
        chk("s1_if_gnt", if_gnt[0], 1'b1);
        chk("s1_d_gnt", d_gnt[0], 1'b0);
        chk("s1_mem_req", mem_req[0], 1'b1);
        chk("s1_mem_addr", mem_addr[0], 32'h10);
        chk("s1_mem_we", mem_we[0], 1'b0);
        chk("s1_mem_be", mem_be[0], 4'hF);
        sb_push(0, 1'b0, 32'h0050_0093, cyc + 1);
        step();
        if_req[0] = 1'b0;
        sample();
        chk("s1_busy_resp", busy[0], 1'b0);

        // Simultaneous requests, MEM_LAT=2: data first, fetch in its response cycle.
        step();
        if_req[1] = 1'b1; if_addr[1] = 32'h40;
        d_req[1]  = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h100;
        sample();
        chk("s2_d_gnt", d_gnt[1], 1'b1);
        chk("s2_if_gnt", if_gnt[1], 1'b0);
        chk("s2_mem_addr", mem_addr[1], 32'h100);
        sb_push(1, 1'b1, mem_fn(32'h100), cyc + 2);
        step();
        d_req[1] = 1'b0;
        sample();
        chk("s2_wait_gnt", {if_gnt[1], d_gnt[1], mem_req[1]}, 3'b000);
        chk("s2_wait_busy", busy[1], 1'b1);
        step();
        sample();
        chk("s2_if_gnt_resp", if_gnt[1], 1'b1);
        chk("s2_mem_addr_if", mem_addr[1], 32'h40);
        chk("s2_busy_overlap", busy[1], 1'b1);
        sb_push(1, 1'b0, mem_fn(32'h40), cyc + 2);
        step();
        if_req[1] = 1'b0;
        sample();
        chk("s2_busy_wait2", busy[1], 1'b1);
        step();
        step();

        // Starvation guard, MEM_LAT=1, STARVE_MAX=4.
        step();
        d_req[0]  = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h300;
        if_req[0] = 1'b1; if_addr[0] = 32'h80;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk($sformatf("s3_d_gnt%0d", i), d_gnt[0], 1'b1);
            chk($sformatf("s3_if_lose%0d", i), if_gnt[0], 1'b0);
            sb_push(0, 1'b1, mem_fn(d_addr[0]), cyc + 1);
            step();
            d_addr[0] = d_addr[0] + 32'd4;
        end
        sample();
        chk("s3_forced_if_gnt", if_gnt[0], 1'b1);
        chk("s3_forced_d_gnt", d_gnt[0], 1'b0);
        chk("s3_forced_addr", mem_addr[0], 32'h80);
        sb_push(0, 1'b0, mem_fn(32'h80), cyc + 1);
        step();
        if_req[0] = 1'b0;
        sample();
        chk("s3_d_resume", d_gnt[0], 1'b1);
        sb_push(0, 1'b1, mem_fn(d_addr[0]), cyc + 1);
`ifdef ARB_PERF_EN
        chk("s3_if_stall", if_stall_cnt[0], 32'd4);
`endif
        step();
        d_req[0] = 1'b0;
        step();

        // Store, MEM_LAT=2.
        d_req[1] = 1'b1; d_we[1] = 1'b1; d_be[1] = 4'b0011;
        d_addr[1] = 32'h200; d_wdata[1] = 32'hDEAD_BEEF;
        sample();
        chk("s4_d_gnt", d_gnt[1], 1'b1);
        chk("s4_mem_we", mem_we[1], 1'b1);
        chk("s4_mem_be", mem_be[1], 4'b0011);
        chk("s4_mem_addr", mem_addr[1], 32'h200);
        chk("s4_mem_wdata", mem_wdata[1], 32'hDEAD_BEEF);
        sb_push(1, 1'b1, mem_fn(32'h200), cyc + 2);
        step();
        d_req[1] = 1'b0; d_we[1] = 1'b0; d_be[1] = '0; d_wdata[1] = '0;
        step();
        step();

        // Withdrawn fetch during a MEM_LAT=3 load: no grant without a request.
        d_req[2] = 1'b1; d_addr[2] = 32'h400;
        sample();
        chk("wd_d_gnt", d_gnt[2], 1'b1);
        sb_push(2, 1'b1, mem_fn(32'h400), cyc + 3);
        step();
        d_req[2] = 1'b0; if_req[2] = 1'b1; if_addr[2] = 32'h44;
        sample();
        chk("wd_if_wait", if_gnt[2], 1'b0);
        step();
        if_req[2] = 1'b0;
        step();
        sample();
        chk("wd_resp_nogrant", {if_gnt[2], d_gnt[2], mem_req[2]}, 3'b000);
        chk("wd_resp_busy", busy[2], 1'b0);
        step();

        // Reset during an outstanding MEM_LAT=3 fetch.
        if_req[2] = 1'b1; if_addr[2] = 32'h60;
        sample();
        chk("s5_if_gnt", if_gnt[2], 1'b1);
        step();
        if_req[2] = 1'b0;
        sample();
        chk("s5_busy", busy[2], 1'b1);
        #2;
        reset = 1'b0;
        if_req[2] = 1'b1; if_addr[2] = 32'h64;
        #1;
        chk_quiet(2, "s5_rst");
        step();
        reset = 1'b1;
        sample();
        chk("s5_regrant", if_gnt[2], 1'b1);
        chk("s5_regrant_addr", mem_addr[2], 32'h64);
        sb_push(2, 1'b0, mem_fn(32'h64), cyc + 3);
        step();
        if_req[2] = 1'b0;

        repeat (6) step();
        for (int k = 0; k < NI; k++) chk($sformatf("sb_drain%0d", k), sb_size(k), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port instruction/data memory between the core's fetch stage and its load/store unit. Issues one memory transaction at a time and returns read data to whichever requester owns it. Sits between the core datapath and the unified memory inside top. Data side has priority, with a starvation guard for fetch.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MEM_LAT, 1, cycles from mem_req to valid mem_rdata (legal 1..4)
STARVE_MAX, 4, consecutive lost arbitrations before fetch is forced to win (legal 1..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held with if_addr stable until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DATA_W  fetched instruction
d_req  in  1  load/store request; held with d_* stable until d_gnt
d_we  in  1  1 = store, 0 = load
d_be  in  DATA_W/8  store byte enables
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  one-cycle pulse: load data valid / store completed
d_rdata  out  DATA_W  load data
mem_req  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_be  out  DATA_W/8  memory byte enables
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_req
busy  out  1  transaction outstanding

Behaviour:
- Reset (asserted low, async): state IDLE, owner cleared, latency counter 0, starve counter 0. All outputs 0. A response in flight is dropped; no rvalid after reset deasserts.
- FSM states: IDLE, WAIT.
- IDLE: if either req is high, grant is combinational in the same cycle. Exactly one gnt is high. mem_req=1 and mem_* are muxed from the winner (fetch: mem_we=0, mem_be=all 1s). Next state is WAIT, owner registered, counter loaded with MEM_LAT.
- WAIT: busy=1 and the counter decrements each cycle. When counter==1, that cycle is the response cycle: owner's rvalid=1 and rdata=mem_rdata (combinational passthrough). For a store, d_rvalid still pulses, with d_rdata=mem_rdata (don't care). Arbiter behaves as IDLE in the response cycle, so a new grant may coincide with rvalid.
- Throughput: one transaction per MEM_LAT cycles. With MEM_LAT=1, back-to-back grants every cycle.
- Priority: d_req wins over if_req, unless starve counter == STARVE_MAX, in which case fetch wins.
- Starve counter: increments (saturating) on each arbitration cycle where if_req=1 and if_gnt=0. Clears on if_gnt or whenever if_req=0.
- gnt never asserts without the matching req. rdata outputs are 0 whenever rvalid=0.
- A requester dropping req before gnt is legal; the request is simply withdrawn.
- busy is 0 in IDLE and in the response cycle unless a new grant occurs there.

Optional Feature:
ARB_PERF_EN
- Defined: adds outputs if_stall_cnt and d_stall_cnt, each 32 bits. Each counts cycles where its req=1 and gnt=0, saturating at all 1s, cleared by reset.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- MEM_LAT=1, if_req, addr 0x10, mem returns 0x00500093 -> if_gnt same cycle; if_rvalid next cycle with if_rdata=0x00500093.
- if_req and d_req (load, 0x100) raised together, MEM_LAT=2 -> d_gnt first, d_rvalid 2 cycles later; if_gnt in that same response cycle; if_rvalid 2 cycles after that.
- d_req held continuously (loads), if_req held, STARVE_MAX=4, MEM_LAT=1 -> fetch loses 4 arbitrations, if_gnt on the 5th, then data resumes.
- Store d_we=1, d_be=4'b0011, addr 0x200, wdata 0xDEADBEEF -> mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF in grant cycle; d_rvalid pulse MEM_LAT cycles later; if_rvalid stays 0.
- MEM_LAT=3, fetch granted, reset low one cycle later -> all outputs 0 immediately; no if_rvalid after reset releases; next if_req granted at once.
- With ARB_PERF_EN, the scenario-3 pattern -> if_stall_cnt=4 after the first forced fetch grant.
